// File: rtl/led_cube_pkg.sv
// Shared types and sizing helpers for the LED cube frame sequencer.
package led_cube_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SHOW  = 3'd3,
    BLANK = 3'd4
  } seq_state_t;

  localparam int DEFAULT_N = 4;

  typedef logic [DEFAULT_N*DEFAULT_N-1:0] cube_layer_t;

  // Bits needed to hold values 0..count-1, never less than one bit.
  function automatic int cnt_width(input int count);
    if (count <= 1) begin
      return 1;
    end else begin
      return $clog2(count);
    end
  endfunction

endpackage

// File: rtl/led_cube_dwell_timer.sv
// Loadable down-counter that times the SHOW and BLANK dwell periods.
module led_cube_dwell_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expired
);

  logic [W-1:0] count;

  // Counts down to zero and holds; a load restarts the dwell.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end else begin
      count <= count;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/led_cube_frame_sequencer.sv
// Multi-frame LED cube scanner: fetches each layer from frame memory,
// shows it for a dwell, blanks, and steps through layers, scans and frames.
module led_cube_frame_sequencer
  import led_cube_pkg::*;
#(
  parameter int N            = 4,
  parameter int NUM_FRAMES   = 8,
  parameter int LAYER_TICKS  = 1000,
  parameter int BLANK_TICKS  = 10,
  parameter int FRAME_REPEAT = 50
) (
  input  logic                                  CLOCK_50,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  stop,
  input  logic                                  loop,
  output logic                                  rd_en,
  output logic [cnt_width(NUM_FRAMES*N)-1:0]    rd_addr,
  input  logic [N*N-1:0]                        rd_data,
  output logic [N-1:0]                          layer_sel,
  output logic [N*N-1:0]                        col_data,
  output logic [cnt_width(NUM_FRAMES)-1:0]      frame_idx,
  output logic                                  busy,
  output logic                                  done
);

  localparam int AW   = cnt_width(NUM_FRAMES*N);
  localparam int FW   = cnt_width(NUM_FRAMES);
  localparam int LW   = cnt_width(N);
  localparam int SW   = cnt_width(FRAME_REPEAT);
  localparam int TMAX = (LAYER_TICKS > BLANK_TICKS) ? LAYER_TICKS : BLANK_TICKS;
  localparam int TW   = cnt_width(TMAX);
  localparam logic [TW-1:0] SHOW_LOAD  = TW'(LAYER_TICKS - 1);
  localparam logic [TW-1:0] BLANK_LOAD = TW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);

  seq_state_t    state;
  logic [LW-1:0] layer;
  logic [SW-1:0] scan;
  logic [LW-1:0] nxt_layer;
  logic [SW-1:0] nxt_scan;
  logic [FW-1:0] nxt_frame;
  logic [AW-1:0] nxt_addr;
  logic          seq_finish;
  logic          step_end;
  logic          timer_load;
  logic [TW-1:0] timer_value;
  logic          timer_expired;

  led_cube_dwell_timer #(.W(TW)) u_dwell (
    .clk        (CLOCK_50),
    .rst        (rst),
    .load       (timer_load),
    .load_value (timer_value),
    .expired    (timer_expired)
  );

  // Next layer/scan/frame position and whether the sequence ends here.
  always_comb begin
    nxt_layer  = layer + LW'(1);
    nxt_scan   = scan;
    nxt_frame  = frame_idx;
    seq_finish = 1'b0;
    if (layer == LW'(N - 1)) begin
      nxt_layer = '0;
      if (scan == SW'(FRAME_REPEAT - 1)) begin
        nxt_scan = '0;
        if (frame_idx == FW'(NUM_FRAMES - 1)) begin
          nxt_frame  = '0;
          seq_finish = !loop;
        end else begin
          nxt_frame = frame_idx + FW'(1);
        end
      end else begin
        nxt_scan = scan + SW'(1);
      end
    end else begin
      nxt_scan = scan;
    end
    nxt_addr = AW'(int'(nxt_frame) * N + int'(nxt_layer));
  end

  // Dwell timer is armed one cycle ahead of each SHOW and BLANK window.
  always_comb begin
    step_end    = 1'b0;
    timer_load  = 1'b0;
    timer_value = SHOW_LOAD;
    if (state == LOAD) begin
      timer_load  = 1'b1;
      timer_value = SHOW_LOAD;
    end else if (state == SHOW && timer_expired) begin
      timer_load  = (BLANK_TICKS != 0);
      timer_value = BLANK_LOAD;
      step_end    = (BLANK_TICKS == 0);
    end else if (state == BLANK && timer_expired) begin
      step_end = 1'b1;
    end else begin
      timer_load = 1'b0;
    end
  end

  // Sequencer state machine with registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (rst || stop) begin
      state     <= IDLE;
      layer     <= '0;
      scan      <= '0;
      frame_idx <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      layer_sel <= '0;
      col_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= FETCH;
            rd_en   <= 1'b1;
            rd_addr <= '0;
            busy    <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        FETCH: begin
          rd_en <= 1'b0;
          state <= LOAD;
        end
        LOAD: begin
          col_data  <= rd_data;
          layer_sel <= N'(1) << layer;
          state     <= SHOW;
        end
        SHOW: begin
          if (timer_expired) begin
            layer_sel <= '0;
            col_data  <= '0;
            state     <= BLANK;
          end else begin
            state <= SHOW;
          end
        end
        BLANK: begin
          state <= BLANK;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      // End of a layer step overrides the per-state next state above.
      if (step_end) begin
        layer     <= nxt_layer;
        scan      <= nxt_scan;
        frame_idx <= nxt_frame;
        if (seq_finish) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          state   <= FETCH;
          rd_en   <= 1'b1;
          rd_addr <= nxt_addr;
        end
      end
    end
  end

endmodule
